mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: NUM_REQ, default 4, number of requesters sharing one mem_handle-style memory port (2..8).
REQ-002 Parameter: ADDR_SIZE, default 24, word-pointer width; the MSB selects the M9K space (1) or the SDRAM space (0) downstream.
REQ-003 clk  input  1  single clock; all logic on posedge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 req_r_en  input  NUM_REQ  per-requester read request.
REQ-006 req_w_en  input  NUM_REQ  per-requester write request.
REQ-007 req_write_through, req_read_through  input  NUM_REQ each  per-requester cache bypass hints.
REQ-008 req_ptr  input  NUM_REQ*ADDR_SIZE  packed; requester i occupies bits [i*ADDR_SIZE +: ADDR_SIZE].
REQ-009 req_data_store  input  NUM_REQ*32  packed; requester i occupies bits [i*32 +: 32].
REQ-010 req_data_load  output  32  read data, shared by all requesters; valid only while the matching req_done bit is high.
REQ-011 req_done  output  NUM_REQ  one-cycle completion pulse to the granted requester.
REQ-012 grant  output  NUM_REQ  one-hot owner of the port; all zero when idle.
REQ-013 mem_r_en, mem_w_en, mem_write_through, mem_read_through  output  1 each  downstream mem_handle controls.
REQ-014 mem_ptr  output  ADDR_SIZE; mem_data_store  output  32; mem_data_load  input  32; mem_done  input  1  downstream mem_handle datapath and one-cycle completion.
REQ-015 busy  output  1  high in any state except IDLE.

Function
REQ-016 FSM states: IDLE, ISSUE, RESP; state, grant and all downstream outputs are registered.
REQ-017 Requester protocol: hold r_en/w_en and operands stable until the cycle req_done[i]=1, then deassert on the next edge.
REQ-018 IDLE: if any (req_r_en|req_w_en) bit is set, pick winner g by round-robin from rr_ptr, then go to ISSUE; otherwise stay in IDLE.
REQ-019 Round-robin order: search indices rr_ptr, rr_ptr+1, ... mod NUM_REQ; the first active index wins.
REQ-020 On grant: set rr_ptr <= (g+1) mod NUM_REQ; set grant <= one-hot(g); latch ptr, data_store and both through-bits of g into internal registers.
REQ-021 ISSUE: drive mem_ptr, mem_data_store and through-bits from the latched copies; changes on the requester's inputs have no effect.
REQ-022 ISSUE: mem_w_en=1 when req_w_en[g] was set at grant; mem_r_en=1 when req_w_en[g]=0 and req_r_en[g]=1.
REQ-023 Both req_r_en[g] and req_w_en[g] high at grant is illegal; the write takes priority and the read is dropped.
REQ-024 ISSUE: hold the mem_* enables until mem_done=1; on that edge latch mem_data_load into req_data_load (reads only) and go to RESP.
REQ-025 RESP: req_done[g]=1 for exactly one cycle; mem_r_en=mem_w_en=0; grant remains one-hot(g); next state IDLE.
REQ-026 Transition into IDLE: grant <= 0.
REQ-027 Latency: request high in IDLE at edge 0 -> mem enables high after edge 0 -> mem_done at edge k -> req_done high during cycle k+1 -> IDLE after edge k+1.
REQ-028 Minimum occupancy per transaction is 3 cycles (IDLE, ISSUE, RESP), including when mem_done arrives in the first ISSUE cycle.
REQ-029 mem_done while in IDLE or RESP: ignored; no state change and no data latch.
REQ-030 Requester raising a request while another requester owns the port: waits; it is arbitrated at the next IDLE.
REQ-031 No starvation: a continuously asserting requester is granted within NUM_REQ transactions.
REQ-032 req_data_load: holds its last value outside RESP; writes do not update it.

Reset
REQ-033 When rst=1 at a clock edge: state=IDLE, rr_ptr=0, grant=0, req_done=0, mem_r_en=mem_w_en=0, mem_write_through=mem_read_through=0, mem_ptr=0, mem_data_store=0, req_data_load=0, busy=0.
REQ-034 Reset during ISSUE or RESP aborts the transaction; no req_done pulse is generated, and a later stray mem_done is ignored per REQ-029.

Verification
REQ-035 Single read: req_r_en[2]=1, ptr=0x800010, mem_done after 4 cycles with mem_data_load=0xDEADBEEF -> mem_r_en high 4 cycles, mem_ptr=0x800010, req_done[2] pulses 1 cycle with req_data_load=0xDEADBEEF.
REQ-036 Fairness: all 4 requesters hold writes from reset -> grant order 0,1,2,3,0; each req_done observed exactly once per round.
REQ-037 Operand isolation: requester 1 changes ptr from 0x000100 to 0x000200 during ISSUE -> mem_ptr stays 0x000100 until mem_done.
REQ-038 Illegal request: r_en=w_en=1 on requester 0, data_store=0x12345678 -> mem_w_en=1, mem_r_en=0, mem_data_store=0x12345678.
REQ-039 Reset mid-ISSUE: assert rst for 1 cycle while requester 3 is granted, then pulse mem_done -> no req_done, grant=0, busy=0, state IDLE, rr_ptr=0.
REQ-040 Zero-wait memory: mem_done high in the first ISSUE cycle -> req_done exactly 2 cycles after the request was sampled; back-to-back requests spaced 3 cycles apart.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter sharing one mem_handle-style memory port
// among NUM_REQ requesters. One transaction at a time: IDLE -> ISSUE -> RESP.
module mem_arbiter #(
    parameter int unsigned NUM_REQ   = 4,
    parameter int unsigned ADDR_SIZE = 24
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_REQ-1:0]             req_r_en,
    input  logic [NUM_REQ-1:0]             req_w_en,
    input  logic [NUM_REQ-1:0]             req_write_through,
    input  logic [NUM_REQ-1:0]             req_read_through,
    input  logic [NUM_REQ*ADDR_SIZE-1:0]   req_ptr,
    input  logic [NUM_REQ*32-1:0]          req_data_store,
    output logic [31:0]                    req_data_load,
    output logic [NUM_REQ-1:0]             req_done,
    output logic [NUM_REQ-1:0]             grant,
    output logic                           mem_r_en,
    output logic                           mem_w_en,
    output logic                           mem_write_through,
    output logic                           mem_read_through,
    output logic [ADDR_SIZE-1:0]           mem_ptr,
    output logic [31:0]                    mem_data_store,
    input  logic [31:0]                    mem_data_load,
    input  logic                           mem_done,
    output logic                           busy
);

    localparam int unsigned PTR_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned DATA_W = 32;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_RESP  = 2'd2
    } state_e;

    state_e                 state_q, state_d;
    logic [PTR_W-1:0]       rr_q, rr_d;
    logic [NUM_REQ-1:0]     grant_q, grant_d;
    logic [NUM_REQ-1:0]     done_q, done_d;
    logic                   mem_r_en_q, mem_r_en_d;
    logic                   mem_w_en_q, mem_w_en_d;
    logic                   mem_wt_q, mem_wt_d;
    logic                   mem_rt_q, mem_rt_d;
    logic [ADDR_SIZE-1:0]   mem_ptr_q, mem_ptr_d;
    logic [DATA_W-1:0]      mem_store_q, mem_store_d;
    logic [DATA_W-1:0]      load_q, load_d;
    logic                   busy_q, busy_d;

    logic [NUM_REQ-1:0]     active;
    logic [PTR_W-1:0]       win_idx;
    logic                   win_found;

    assign active = req_r_en | req_w_en;

    // Round-robin search: first active index starting at rr_q, wrapping.
    always_comb begin
        logic [PTR_W-1:0] idx;
        win_idx   = '0;
        win_found = 1'b0;
        idx       = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            idx = PTR_W'((32'(rr_q) + i) % NUM_REQ);
            if (!win_found && active[idx]) begin
                win_found = 1'b1;
                win_idx   = idx;
            end
        end
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d     = state_q;
        rr_d        = rr_q;
        grant_d     = grant_q;
        done_d      = '0;
        mem_r_en_d  = mem_r_en_q;
        mem_w_en_d  = mem_w_en_q;
        mem_wt_d    = mem_wt_q;
        mem_rt_d    = mem_rt_q;
        mem_ptr_d   = mem_ptr_q;
        mem_store_d = mem_store_q;
        load_d      = load_q;

        case (state_q)
            S_IDLE: begin
                if (win_found) begin
                    state_d     = S_ISSUE;
                    rr_d        = PTR_W'((32'(win_idx) + 1) % NUM_REQ);
                    grant_d     = NUM_REQ'(1) << win_idx;
                    mem_ptr_d   = req_ptr[32'(win_idx)*ADDR_SIZE +: ADDR_SIZE];
                    mem_store_d = req_data_store[32'(win_idx)*DATA_W +: DATA_W];
                    mem_wt_d    = req_write_through[win_idx];
                    mem_rt_d    = req_read_through[win_idx];
                    // A simultaneous read is dropped in favour of the write.
                    mem_w_en_d  = req_w_en[win_idx];
                    mem_r_en_d  = !req_w_en[win_idx] && req_r_en[win_idx];
                end
            end
            S_ISSUE: begin
                if (mem_done) begin
                    state_d    = S_RESP;
                    done_d     = grant_q;
                    mem_r_en_d = 1'b0;
                    mem_w_en_d = 1'b0;
                    if (mem_r_en_q) begin
                        load_d = mem_data_load;
                    end
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
                grant_d = '0;
            end
            default: begin
                state_d    = S_IDLE;
                grant_d    = '0;
                mem_r_en_d = 1'b0;
                mem_w_en_d = 1'b0;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            rr_q        <= '0;
            grant_q     <= '0;
            done_q      <= '0;
            mem_r_en_q  <= 1'b0;
            mem_w_en_q  <= 1'b0;
            mem_wt_q    <= 1'b0;
            mem_rt_q    <= 1'b0;
            mem_ptr_q   <= '0;
            mem_store_q <= '0;
            load_q      <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_q        <= rr_d;
            grant_q     <= grant_d;
            done_q      <= done_d;
            mem_r_en_q  <= mem_r_en_d;
            mem_w_en_q  <= mem_w_en_d;
            mem_wt_q    <= mem_wt_d;
            mem_rt_q    <= mem_rt_d;
            mem_ptr_q   <= mem_ptr_d;
            mem_store_q <= mem_store_d;
            load_q      <= load_d;
            busy_q      <= busy_d;
        end
    end

    assign req_data_load     = load_q;
    assign req_done          = done_q;
    assign grant             = grant_q;
    assign mem_r_en          = mem_r_en_q;
    assign mem_w_en          = mem_w_en_q;
    assign mem_write_through = mem_wt_q;
    assign mem_read_through  = mem_rt_q;
    assign mem_ptr           = mem_ptr_q;
    assign mem_data_store    = mem_store_q;
    assign busy              = busy_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter (NUM_REQ=4, ADDR_SIZE=24).
// Inputs change and outputs are sampled on the falling edge.
module tb_mem_arbiter;

    localparam int unsigned NR = 4;
    localparam int unsigned AW = 24;

    logic                 clk;
    logic                 rst;
    logic [NR-1:0]        req_r_en;
    logic [NR-1:0]        req_w_en;
    logic [NR-1:0]        req_write_through;
    logic [NR-1:0]        req_read_through;
    logic [NR*AW-1:0]     req_ptr;
    logic [NR*32-1:0]     req_data_store;
    logic [31:0]          req_data_load;
    logic [NR-1:0]        req_done;
    logic [NR-1:0]        grant;
    logic                 mem_r_en;
    logic                 mem_w_en;
    logic                 mem_write_through;
    logic                 mem_read_through;
    logic [AW-1:0]        mem_ptr;
    logic [31:0]          mem_data_store;
    logic [31:0]          mem_data_load;
    logic                 mem_done;
    logic                 busy;

    int n_cmp;
    int n_err;

    mem_arbiter #(.NUM_REQ(NR), .ADDR_SIZE(AW)) dut (
        .clk               (clk),
        .rst               (rst),
        .req_r_en          (req_r_en),
        .req_w_en          (req_w_en),
        .req_write_through (req_write_through),
        .req_read_through  (req_read_through),
        .req_ptr           (req_ptr),
        .req_data_store    (req_data_store),
        .req_data_load     (req_data_load),
        .req_done          (req_done),
        .grant             (grant),
        .mem_r_en          (mem_r_en),
        .mem_w_en          (mem_w_en),
        .mem_write_through (mem_write_through),
        .mem_read_through  (mem_read_through),
        .mem_ptr           (mem_ptr),
        .mem_data_store    (mem_data_store),
        .mem_data_load     (mem_data_load),
        .mem_done          (mem_done),
        .busy              (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic nxt();
        @(negedge clk);
    endtask

    initial begin
        logic [NR-1:0] exp_g;
        clk = 1'b0;
        n_cmp = 0;
        n_err = 0;
        rst = 1'b1;
        req_r_en = '0;
        req_w_en = '0;
        req_write_through = '0;
        req_read_through = '0;
        req_ptr = '0;
        req_data_store = '0;
        mem_data_load = '0;
        mem_done = 1'b0;

        // Reset state
        nxt(); nxt();
        chk("rst_grant", 32'(grant), 32'h0);
        chk("rst_done", 32'(req_done), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_men", {30'h0, mem_r_en, mem_w_en}, 32'h0);
        chk("rst_through", {30'h0, mem_write_through, mem_read_through}, 32'h0);
        chk("rst_ptr", 32'(mem_ptr), 32'h0);
        chk("rst_store", mem_data_store, 32'h0);
        chk("rst_load", req_data_load, 32'h0);
        rst = 1'b0;
        nxt();
        chk("idle_busy", 32'(busy), 32'h0);

        // Single read from requester 2, memory answers after 4 cycles
        req_r_en[2] = 1'b1;
        req_ptr[2*AW +: AW] = 24'h800010;
        req_read_through[2] = 1'b1;
        nxt();
        chk("rd_grant", 32'(grant), 32'h4);
        chk("rd_busy", 32'(busy), 32'h1);
        chk("rd_ptr", 32'(mem_ptr), 32'h800010);
        chk("rd_wen", 32'(mem_w_en), 32'h0);
        chk("rd_rthru", 32'(mem_read_through), 32'h1);
        for (int c = 0; c < 4; c++) begin
            chk("rd_ren_hold", 32'(mem_r_en), 32'h1);
            chk("rd_no_done", 32'(req_done), 32'h0);
            if (c == 3) begin
                mem_done = 1'b1;
                mem_data_load = 32'hDEADBEEF;
            end else begin
                nxt();
            end
        end
        nxt();
        mem_done = 1'b0;
        chk("rd_done", 32'(req_done), 32'h4);
        chk("rd_data", req_data_load, 32'hDEADBEEF);
        chk("rd_ren_off", 32'(mem_r_en), 32'h0);
        chk("rd_resp_grant", 32'(grant), 32'h4);
        chk("rd_resp_busy", 32'(busy), 32'h1);
        req_r_en[2] = 1'b0;
        req_read_through[2] = 1'b0;
        nxt();
        chk("rd_idle_grant", 32'(grant), 32'h0);
        chk("rd_idle_busy", 32'(busy), 32'h0);
        chk("rd_idle_done", 32'(req_done), 32'h0);
        chk("rd_data_hold", req_data_load, 32'hDEADBEEF);

        // Operand isolation on requester 1; stray mem_done in RESP/IDLE ignored
        req_r_en[1] = 1'b1;
        req_ptr[1*AW +: AW] = 24'h000100;
        nxt();
        chk("iso_grant", 32'(grant), 32'h2);
        chk("iso_ptr0", 32'(mem_ptr), 32'h000100);
        req_ptr[1*AW +: AW] = 24'h000200;
        nxt();
        chk("iso_ptr1", 32'(mem_ptr), 32'h000100);
        mem_done = 1'b1;
        mem_data_load = 32'h11112222;
        nxt();
        chk("iso_done", 32'(req_done), 32'h2);
        chk("iso_data", req_data_load, 32'h11112222);
        req_r_en[1] = 1'b0;
        mem_data_load = 32'h99999999;
        nxt();
        chk("stray_busy", 32'(busy), 32'h0);
        chk("stray_data", req_data_load, 32'h11112222);
        nxt();
        mem_done = 1'b0;
        chk("stray_idle_busy", 32'(busy), 32'h0);
        chk("stray_idle_done", 32'(req_done), 32'h0);
        chk("stray_idle_data", req_data_load, 32'h11112222);

        // Illegal read+write on requester 0: write wins, load not updated
        req_r_en[0] = 1'b1;
        req_w_en[0] = 1'b1;
        req_write_through[0] = 1'b1;
        req_data_store[0 +: 32] = 32'h12345678;
        nxt();
        chk("ill_grant", 32'(grant), 32'h1);
        chk("ill_wen", 32'(mem_w_en), 32'h1);
        chk("ill_ren", 32'(mem_r_en), 32'h0);
        chk("ill_store", mem_data_store, 32'h12345678);
        chk("ill_wthru", 32'(mem_write_through), 32'h1);
        mem_done = 1'b1;
        mem_data_load = 32'hCAFEF00D;
        nxt();
        mem_done = 1'b0;
        chk("ill_done", 32'(req_done), 32'h1);
        chk("ill_load_kept", req_data_load, 32'h11112222);
        chk("ill_wen_off", 32'(mem_w_en), 32'h0);
        req_r_en[0] = 1'b0;
        req_w_en[0] = 1'b0;
        req_write_through[0] = 1'b0;
        nxt();
        chk("ill_idle_busy", 32'(busy), 32'h0);

        // Reset while requester 3 owns the port, then a stray mem_done
        req_r_en[3] = 1'b1;
        req_ptr[3*AW +: AW] = 24'h000333;
        nxt();
        chk("rst3_grant", 32'(grant), 32'h8);
        rst = 1'b1;
        nxt();
        rst = 1'b0;
        req_r_en[3] = 1'b0;
        chk("rst3_grant0", 32'(grant), 32'h0);
        chk("rst3_busy", 32'(busy), 32'h0);
        chk("rst3_ren", 32'(mem_r_en), 32'h0);
        chk("rst3_ptr", 32'(mem_ptr), 32'h0);
        mem_done = 1'b1;
        nxt();
        mem_done = 1'b0;
        chk("rst3_no_done", 32'(req_done), 32'h0);
        chk("rst3_idle_busy", 32'(busy), 32'h0);
        chk("rst3_idle_grant", 32'(grant), 32'h0);

        // Fairness with zero-wait memory: order 0,1,2,3,0, 3 cycles each
        req_w_en = 4'hF;
        for (int t = 0; t < 5; t++) begin
            exp_g = NR'(1) << (t % NR);
            nxt();
            chk("rr_grant", 32'(grant), 32'(exp_g));
            chk("rr_wen", 32'(mem_w_en), 32'h1);
            chk("rr_no_done", 32'(req_done), 32'h0);
            mem_done = 1'b1;
            nxt();
            mem_done = 1'b0;
            chk("rr_done", 32'(req_done), 32'(exp_g));
            if (t == 4) begin
                req_w_en = '0;
            end
            nxt();
            chk("rr_idle_grant", 32'(grant), 32'h0);
            chk("rr_idle_done", 32'(req_done), 32'h0);
            chk("rr_idle_busy", 32'(busy), 32'h0);
        end
        nxt();
        chk("end_busy", 32'(busy), 32'h0);
        chk("end_grant", 32'(grant), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
